// File: rtl/udma_i2c_slave.sv
// I2C target engine: filtered SCL/SDA, START/STOP detection, 7-bit address match,
// valid/ready RX and TX byte streams, SCL stretching while a stream is not ready.
module udma_i2c_slave #(
  parameter int FILTER_LEN = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_en_i,
  input  logic [6:0] cfg_addr_i,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       evt_start_o,
  output logic       evt_stop_o,
  output logic       evt_match_o,
  output logic       nack_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

  state_t     state;
  logic       scl_p0, scl_p1, sda_p0, sda_p1;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, tx_sh;
  logic       rw, first;
  logic       scl_rise, scl_fall, start_det, stop_det, tx_take;

  // Level moves only after FILT_MAX+1 consecutive samples disagree with it.
  function automatic logic [3:0] filt_next(input logic smp, input logic flt,
                                           input logic [2:0] cnt);
    if (smp == flt) return {flt, 3'd0};
    if (cnt == FILT_MAX) return {smp, 3'd0};
    return {flt, cnt + 3'd1};
  endfunction

  // Stage p0/p1: two-flop synchronizers, then glitch filter and edge history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; sda_p0 <= 1'b1; sda_p1 <= 1'b1;
      scl_f  <= 1'b1; sda_f  <= 1'b1; scl_q  <= 1'b1; sda_q  <= 1'b1;
      scl_cnt <= 3'd0; sda_cnt <= 3'd0;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      {scl_f, scl_cnt} <= filt_next(scl_p1, scl_f, scl_cnt);
      {sda_f, sda_cnt} <= filt_next(sda_p1, sda_f, sda_cnt);
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign tx_take   = ~rst_i & cfg_en_i & ~start_det & ~stop_det &
                     (state == RD_LOAD) & tx_valid_i;
  assign tx_ready_o = tx_take;
  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      scl_oe <= 1'b0; sda_oe <= 1'b0;
      rx_valid_o <= 1'b0; rx_first_o <= 1'b0;
      evt_start_o <= 1'b0; evt_stop_o <= 1'b0; evt_match_o <= 1'b0;
      nack_o <= 1'b0; busy_o <= 1'b0;
      bit_cnt <= 4'd0; rw <= 1'b0; first <= 1'b0;
    end else begin
      evt_start_o <= 1'b0;
      evt_stop_o  <= 1'b0;
      evt_match_o <= 1'b0;
      nack_o      <= 1'b0;
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
        rx_first_o <= 1'b0;
      end
      if (!cfg_en_i) begin
        state <= IDLE;
        scl_oe <= 1'b0; sda_oe <= 1'b0;
        rx_valid_o <= 1'b0; rx_first_o <= 1'b0; busy_o <= 1'b0;
      end else if (start_det) begin
        state <= ADDR; bit_cnt <= 4'd0;
        evt_start_o <= 1'b1; busy_o <= 1'b1;
        scl_oe <= 1'b0; sda_oe <= 1'b0;
      end else if (stop_det) begin
        state <= IDLE; evt_stop_o <= 1'b1; busy_o <= 1'b0;
        scl_oe <= 1'b0; sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == cfg_addr_i) begin
                state <= ADDR_ACK; rw <= shreg[0];
                sda_oe <= 1'b1; evt_match_o <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            first <= 1'b1;
            state <= rw ? RD_LOAD : WR_DATA;
          end
          WR_DATA: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_o <= {shreg[6:0], sda_f};
              rx_valid_o <= 1'b1; rx_first_o <= first;
              first <= 1'b0; state <= WR_ACK;
            end
          end
          // bit_cnt 8: waiting to ACK (stretching if the byte is unconsumed); 9: ACK on bus
          WR_ACK: begin
            if (bit_cnt == 4'd8) begin
              if (scl_fall || scl_oe) begin
                if (rx_valid_o && !rx_ready_i) scl_oe <= 1'b1;
                else begin
                  sda_oe <= 1'b1; bit_cnt <= 4'd9;
                end
              end
            end else begin
              scl_oe <= 1'b0;
              if (scl_fall) begin
                sda_oe <= 1'b0; bit_cnt <= 4'd0; state <= WR_DATA;
              end
            end
          end
          RD_LOAD: begin
            if (tx_take) begin
              tx_sh <= {tx_data_i[6:0], 1'b0};
              sda_oe <= ~tx_data_i[7];
              bit_cnt <= 4'd0; state <= RD_DATA;
            end else begin
              scl_oe <= 1'b1;
            end
          end
          // SCL is released one cycle after the MSB is placed, giving data setup
          RD_DATA: begin
            scl_oe <= 1'b0;
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0; state <= RD_ACK;
              end else begin
                sda_oe <= ~tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_f) begin
              nack_o <= 1'b1; state <= IGNORE;
            end else if (scl_fall) begin
              state <= RD_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_i2c_slave.sv
// Directed bench for udma_i2c_slave: an open-drain I2C master model on a wired-AND bus,
// with immediate assertions on bus responses, stream ports and event pulses.
`timescale 1ns/1ps
module tb_udma_i2c_slave;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst, en, rx_ready, tx_valid;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic       scl_m, sda_m;
  logic       scl_bus, sda_bus;
  logic       scl_o_w, scl_oe_w, sda_o_w, sda_oe_w;
  logic [7:0] rx_data_w;
  logic       rx_valid_w, rx_first_w, tx_ready_w;
  logic       evt_start_w, evt_stop_w, evt_match_w, nack_w, busy_w;

  int checks = 0, errors = 0;
  int n_start = 0, n_stop = 0, n_match = 0, n_nack = 0, n_tx = 0;
  int n_sda = 0, n_scl = 0, n_ovl = 0, rx_n = 0;
  logic [7:0] rx_d [16];
  logic       rx_f [16];
  int b_start, b_stop, b_match, b_nack, b_tx, b_sda, b_scl, b_ovl, b_rx;

  always #5 clk = ~clk;
  assign scl_bus = scl_m & ~scl_oe_w;
  assign sda_bus = sda_m & ~sda_oe_w;

  udma_i2c_slave #(.FILTER_LEN(2)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(en), .cfg_addr_i(addr),
    .scl_i(scl_bus), .scl_o(scl_o_w), .scl_oe(scl_oe_w),
    .sda_i(sda_bus), .sda_o(sda_o_w), .sda_oe(sda_oe_w),
    .rx_data_o(rx_data_w), .rx_valid_o(rx_valid_w), .rx_ready_i(rx_ready),
    .rx_first_o(rx_first_w), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready_w), .evt_start_o(evt_start_w), .evt_stop_o(evt_stop_w),
    .evt_match_o(evt_match_w), .nack_o(nack_w), .busy_o(busy_w)
  );

  always @(negedge clk) begin
    if (evt_start_w) n_start <= n_start + 1;
    if (evt_stop_w)  n_stop  <= n_stop + 1;
    if (evt_match_w) n_match <= n_match + 1;
    if (nack_w)      n_nack  <= n_nack + 1;
    if (tx_ready_w)  n_tx    <= n_tx + 1;
    if (sda_oe_w)    n_sda   <= n_sda + 1;
    if (scl_oe_w)    n_scl   <= n_scl + 1;
    if (sda_oe_w && rx_valid_w) n_ovl <= n_ovl + 1;
    if (rx_valid_w && rx_ready && rx_n < 16) begin
      rx_d[rx_n] <= rx_data_w;
      rx_f[rx_n] <= rx_first_w;
      rx_n <= rx_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_start = n_start; b_stop = n_stop; b_match = n_match; b_nack = n_nack;
    b_tx = n_tx; b_sda = n_sda; b_scl = n_scl; b_ovl = n_ovl; b_rx = rx_n;
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (!scl_bus && n < 4000) begin
      tick(1);
      n++;
    end
    if (!scl_bus) chk("scl_release_timeout", int'(scl_bus), 1);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    tick(HALF / 2);
    sda_m = b;
    tick(HALF / 2);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HALF / 2);
    s = sda_bus;
    tick(HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(HALF / 2 + 3);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HALF);
    sda_m = 1'b0;
    tick(HALF);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(HALF / 2 + 3);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HALF);
    sda_m = 1'b1;
    tick(HALF);
  endtask

  task automatic tx_push(input int dly, input logic [7:0] d);
    int n = 0;
    if (dly > 0) tick(dly);
    tx_data = d;
    tx_valid = 1'b1;
    #1;
    while (!tx_ready_w && n < 4000) begin
      tick(1);
      n++;
    end
    chk("tx_handshake_seen", int'(tx_ready_w), 1);
    tick(1);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic ack;
    logic [7:0] d1, d2;
    int wn;
    scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1; en = 1'b1; addr = 7'h42;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    tick(4);
    chk("rst_scl_oe", int'(scl_oe_w), 0);
    chk("rst_sda_oe", int'(sda_oe_w), 0);
    chk("rst_rx_valid", int'(rx_valid_w), 0);
    chk("rst_rx_first", int'(rx_first_w), 0);
    chk("rst_tx_ready", int'(tx_ready_w), 0);
    chk("rst_evts", int'({evt_start_w, evt_stop_w, evt_match_w, nack_w}), 0);
    chk("rst_busy", int'(busy_w), 0);
    chk("pad_outs", int'({scl_o_w, sda_o_w}), 0);
    rst = 1'b0;
    tick(4);

    // Plain write of two bytes to own address 0x42
    snap();
    i2c_start();
    chk("wr_busy", int'(busy_w), 1);
    write_byte(8'h84, ack); chk("wr_addr_ack", int'(ack), 0);
    write_byte(8'hA5, ack); chk("wr_b0_ack", int'(ack), 0);
    write_byte(8'h3C, ack); chk("wr_b1_ack", int'(ack), 0);
    i2c_stop();
    tick(5);
    chk("wr_rx_count", rx_n - b_rx, 2);
    chk("wr_rx0", int'(rx_d[b_rx]), 'hA5);
    chk("wr_rx0_first", int'(rx_f[b_rx]), 1);
    chk("wr_rx1", int'(rx_d[b_rx + 1]), 'h3C);
    chk("wr_rx1_first", int'(rx_f[b_rx + 1]), 0);
    chk("wr_starts", n_start - b_start, 1);
    chk("wr_matches", n_match - b_match, 1);
    chk("wr_stops", n_stop - b_stop, 1);
    chk("wr_busy_end", int'(busy_w), 0);

    // Address 0x43 does not match
    snap();
    i2c_start();
    write_byte(8'h86, ack); chk("mm_addr_nack", int'(ack), 1);
    write_byte(8'h55, ack); chk("mm_data_nack", int'(ack), 1);
    chk("mm_busy", int'(busy_w), 1);
    i2c_stop();
    tick(5);
    chk("mm_sda_never", n_sda - b_sda, 0);
    chk("mm_no_rx", rx_n - b_rx, 0);
    chk("mm_no_match", n_match - b_match, 0);
    chk("mm_busy_end", int'(busy_w), 0);

    // Read with a late TX source; master ACKs 0x96 then NACKs 0x0F
    snap();
    i2c_start();
    write_byte(8'h85, ack); chk("rd_addr_ack", int'(ack), 0);
    fork
      tx_push(200, 8'h96);
      read_byte(d1, 1'b0);
    join
    wn = n_scl - b_scl;
    chk("rd_stretch_min", int'(wn >= 180), 1);
    chk("rd_stretch_max", int'(wn <= 220), 1);
    fork
      tx_push(0, 8'h0F);
      read_byte(d2, 1'b1);
    join
    i2c_stop();
    tick(5);
    chk("rd_byte0", int'(d1), 'h96);
    chk("rd_byte1", int'(d2), 'h0F);
    chk("rd_tx_ready_pulses", n_tx - b_tx, 2);
    chk("rd_nack_pulses", n_nack - b_nack, 1);
    chk("rd_busy_end", int'(busy_w), 0);

    // RX backpressure: consumer holds off 100 cycles
    rx_ready = 1'b0;
    snap();
    i2c_start();
    write_byte(8'h84, ack); chk("bp_addr_ack", int'(ack), 0);
    fork
      write_byte(8'h11, ack);
      begin
        wn = 0;
        while (!rx_valid_w && wn < 4000) begin
          tick(1);
          wn++;
        end
        tick(50);
        chk("bp_mid_scl_oe", int'(scl_oe_w), 1);
        chk("bp_mid_sda_oe", int'(sda_oe_w), 0);
        chk("bp_mid_rx_valid", int'(rx_valid_w), 1);
        tick(50);
        rx_ready = 1'b1;
      end
    join
    chk("bp_data_ack", int'(ack), 0);
    i2c_stop();
    tick(5);
    wn = n_scl - b_scl;
    chk("bp_stretch_min", int'(wn >= 80), 1);
    chk("bp_stretch_max", int'(wn <= 110), 1);
    chk("bp_rx_once", rx_n - b_rx, 1);
    chk("bp_rx_data", int'(rx_d[b_rx]), 'h11);
    chk("bp_ack_after_hs", n_ovl - b_ovl, 0);

    // Write then repeated START into a one-byte read
    snap();
    i2c_start();
    write_byte(8'h84, ack); chk("sr_waddr_ack", int'(ack), 0);
    write_byte(8'h01, ack); chk("sr_wdata_ack", int'(ack), 0);
    i2c_start();
    write_byte(8'h85, ack); chk("sr_raddr_ack", int'(ack), 0);
    fork
      tx_push(0, 8'h5A);
      read_byte(d1, 1'b1);
    join
    chk("sr_busy_mid", int'(busy_w), 1);
    chk("sr_no_stop_mid", n_stop - b_stop, 0);
    i2c_stop();
    tick(5);
    chk("sr_starts", n_start - b_start, 2);
    chk("sr_matches", n_match - b_match, 2);
    chk("sr_rx_count", rx_n - b_rx, 1);
    chk("sr_rx_data", int'(rx_d[b_rx]), 'h01);
    chk("sr_rx_first", int'(rx_f[b_rx]), 1);
    chk("sr_rd_byte", int'(d1), 'h5A);
    chk("sr_nack", n_nack - b_nack, 1);

    // One-cycle SDA glitches while SCL is high
    snap();
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    tick(10);
    chk("gl_no_start", n_start - b_start, 0);
    chk("gl_idle_busy", int'(busy_w), 0);
    sda_m = 1'b0;
    tick(10);
    chk("gl_real_start", n_start - b_start, 1);
    sda_m = 1'b1;
    tick(1);
    sda_m = 1'b0;
    tick(10);
    chk("gl_no_stop", n_stop - b_stop, 0);
    chk("gl_busy_held", int'(busy_w), 1);
    scl_m = 1'b0;
    tick(HALF);
    i2c_stop();
    tick(5);
    chk("gl_busy_end", int'(busy_w), 0);

    // Reset while stretching in a read
    snap();
    i2c_start();
    write_byte(8'h85, ack); chk("rs_addr_ack", int'(ack), 0);
    tick(20);
    scl_m = 1'b1;
    tick(5);
    chk("rs_pre_scl_oe", int'(scl_oe_w), 1);
    chk("rs_pre_bus_low", int'(scl_bus), 0);
    rst = 1'b1;
    tick(1);
    chk("rs_scl_oe", int'(scl_oe_w), 0);
    chk("rs_sda_oe", int'(sda_oe_w), 0);
    chk("rs_busy", int'(busy_w), 0);
    rst = 1'b0;
    tick(10);
    chk("rs_bus_free", int'(scl_bus & sda_bus), 1);
    snap();
    i2c_start();
    write_byte(8'h84, ack); chk("rs_recover_ack", int'(ack), 0);
    i2c_stop();
    tick(5);
    chk("rs_recover_match", n_match - b_match, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
